// File: rtl/trit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trit_pkg
//  Purpose  : Shared trit encodings, FSM state encoding and trit arithmetic
//             helpers for the trit-serial SPI master.
//  Revision : 1.0  initial release
// ============================================================================
package trit_pkg;

  // Trit encoding on every 2-bit bus
  localparam logic [1:0] TRIT_Z = 2'b00;  // 0
  localparam logic [1:0] TRIT_P = 2'b01;  // +1
  localparam logic [1:0] TRIT_N = 2'b10;  // -1
  localparam logic [1:0] TRIT_X = 2'b11;  // invalid

  // sck trit-clock phases
  localparam logic [1:0] SCK_IDLE   = 2'b00;
  localparam logic [1:0] SCK_LAUNCH = 2'b01;
  localparam logic [1:0] SCK_SAMPLE = 2'b10;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LAUNCH = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_CKSUM  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LAUNCH = ST_LAUNCH,
    S_SAMPLE = ST_SAMPLE,
    S_CKSUM  = ST_CKSUM,
    S_DONE   = ST_DONE
  } state_t;

  function automatic logic trit_valid(input logic [1:0] t);
    return (t != TRIT_X);
  endfunction

  // Invalid trits collapse to zero wherever they are consumed
  function automatic logic [1:0] trit_fix(input logic [1:0] t);
    return trit_valid(t) ? t : TRIT_Z;
  endfunction

  function automatic int trit_val(input logic [1:0] t);
    if (t == TRIT_P) return 1;
    else if (t == TRIT_N) return -1;
    else return 0;
  endfunction

  // Balanced mod-3 sum: result folded back into {-1,0,+1}
  function automatic logic [1:0] trit_add3(input logic [1:0] a, input logic [1:0] b);
    int s;
    s = trit_val(a) + trit_val(b);
    if (s > 1) s = s - 3;
    else if (s < -1) s = s + 3;
    if (s == 1) return TRIT_P;
    else if (s == -1) return TRIT_N;
    else return TRIT_Z;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trit_sck_gen.sv
`default_nettype none
// ============================================================================
//  Module   : trit_sck_gen
//  Purpose  : Half-period counter for the trit clock. Flags the first and the
//             last (CLKDIV-th) cycle of each sck phase. Restarted explicitly
//             when a transfer is accepted; wraps on its own at phase end.
//  Revision : 1.0  initial release
// ============================================================================
module trit_sck_gen #(
  parameter int CLKDIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,      // synchronous, active-low
  input  logic i_restart,
  output logic o_first,
  output logic o_done
);

  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKDIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_first = (r_cnt == '0);
  assign o_done  = (r_cnt == C_LAST);

  // Count cycles within a phase; each phase end or restart begins a new phase
  always_ff @(posedge i_clk) begin
    if (!i_rst || i_restart || o_done) r_cnt <= '0;
    else                               r_cnt <= r_cnt + 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/trit_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : trit_spi_master
//  Purpose  : Trit-serial SPI master. Shifts an NTRITS-trit word out on mosi,
//             MS trit first, one trit per sck period, while capturing the
//             slave's reply on miso.
//  Options  : TRIT_SPI_CKSUM_EN - append a balanced mod-3 checksum trit
//             exchange after the data trits and flag a reply mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module trit_spi_master
  import trit_pkg::*;
#(
  parameter int NTRITS = 3,
  parameter int CLKDIV = 4
) (
  input  logic                I_clk,
  input  logic                I_rst,
  input  logic [2*NTRITS-1:0] I_tx_data,
  input  logic                I_tx_valid,
  output logic                O_tx_ready,
  output logic [2*NTRITS-1:0] O_rx_data,
  output logic                O_rx_valid,
  output logic                O_rx_err,
  output logic [1:0]          O_mosi,
  input  logic [1:0]          I_miso,
  output logic [1:0]          O_sck
);

  localparam int W   = 2 * NTRITS;
  localparam int TCW = $clog2(NTRITS + 1);
  localparam logic [TCW-1:0] C_TLAST = TCW'(NTRITS - 1);

  state_t         r_state;
  logic [W-1:0]   r_tx_sh;
  logic [W-1:0]   r_rx_sh;
  logic [TCW-1:0] r_tcnt;
  logic           r_err;
`ifdef TRIT_SPI_CKSUM_EN
  logic [1:0]     r_tx_sum;
  logic [1:0]     r_rx_sum;
  logic           r_ck_half;   // 0: checksum launch phase, 1: sample phase
`endif

  logic           w_accept;
  logic           w_first;
  logic           w_done;
  logic [W-1:0]   w_tx_shl;
  logic [1:0]     w_tx_first;
  logic [1:0]     w_tx_next;
  logic [1:0]     w_miso;
  logic           w_miso_bad;
  logic [W-1:0]   w_rx_shl;

  assign w_accept   = (r_state == S_IDLE) && I_tx_valid && O_tx_ready;
  assign w_tx_shl   = r_tx_sh << 2;
  assign w_tx_first = trit_fix(I_tx_data[W-1 -: 2]);
  assign w_tx_next  = trit_fix(w_tx_shl[W-1 -: 2]);
  assign w_miso     = trit_fix(I_miso);
  assign w_miso_bad = !trit_valid(I_miso);
  assign w_rx_shl   = (r_rx_sh << 2) | W'(w_miso);

  trit_sck_gen #(
    .CLKDIV (CLKDIV)
  ) u_sck_gen (
    .i_clk     (I_clk),
    .i_rst     (I_rst),
    .i_restart (w_accept),
    .o_first   (w_first),
    .o_done    (w_done)
  );

  // Transfer FSM: all pin-facing outputs are registered here
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      r_state    <= S_IDLE;
      O_tx_ready <= 1'b1;
      O_rx_data  <= '0;
      O_rx_valid <= 1'b0;
      O_rx_err   <= 1'b0;
      O_mosi     <= TRIT_Z;
      O_sck      <= SCK_IDLE;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
`ifdef TRIT_SPI_CKSUM_EN
      r_tx_sum   <= TRIT_Z;
      r_rx_sum   <= TRIT_Z;
      r_ck_half  <= 1'b0;
`endif
    end else begin
      O_rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tx_sh    <= I_tx_data;
            r_rx_sh    <= '0;
            r_tcnt     <= '0;
            r_err      <= 1'b0;
            O_tx_ready <= 1'b0;
            O_sck      <= SCK_LAUNCH;
            O_mosi     <= w_tx_first;
            r_state    <= S_LAUNCH;
`ifdef TRIT_SPI_CKSUM_EN
            r_tx_sum   <= w_tx_first;
            r_rx_sum   <= TRIT_Z;
            r_ck_half  <= 1'b0;
`endif
          end
        end
        S_LAUNCH: begin
          if (w_done) begin
            O_sck   <= SCK_SAMPLE;
            r_state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          // miso is taken once, on the first cycle of the sample phase
          if (w_first) begin
            r_rx_sh  <= w_rx_shl;
            r_err    <= r_err | w_miso_bad;
`ifdef TRIT_SPI_CKSUM_EN
            r_rx_sum <= trit_add3(r_rx_sum, w_miso);
`endif
          end
          if (w_done) begin
            if (r_tcnt == C_TLAST) begin
`ifdef TRIT_SPI_CKSUM_EN
              O_sck     <= SCK_LAUNCH;
              O_mosi    <= r_tx_sum;
              r_ck_half <= 1'b0;
              r_state   <= S_CKSUM;
`else
              O_sck     <= SCK_IDLE;
              O_mosi    <= TRIT_Z;
              r_state   <= S_DONE;
`endif
            end else begin
              r_tcnt   <= r_tcnt + 1'b1;
              r_tx_sh  <= w_tx_shl;
              O_mosi   <= w_tx_next;
              O_sck    <= SCK_LAUNCH;
              r_state  <= S_LAUNCH;
`ifdef TRIT_SPI_CKSUM_EN
              r_tx_sum <= trit_add3(r_tx_sum, w_tx_next);
`endif
            end
          end
        end
`ifdef TRIT_SPI_CKSUM_EN
        S_CKSUM: begin
          // An invalid checksum trit never equals the running sum, so it also flags
          if (r_ck_half && w_first) begin
            r_err <= r_err | (I_miso != r_rx_sum);
          end
          if (w_done) begin
            if (!r_ck_half) begin
              r_ck_half <= 1'b1;
              O_sck     <= SCK_SAMPLE;
            end else begin
              O_sck     <= SCK_IDLE;
              O_mosi    <= TRIT_Z;
              r_state   <= S_DONE;
            end
          end
        end
`endif
        S_DONE: begin
          O_rx_valid <= 1'b1;
          O_rx_data  <= r_rx_sh;
          O_rx_err   <= r_err;
          O_tx_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
